// File: rtl/pipe_event_counter.sv
// Cycle and event counter bank with a programmable stop limit, an atomic snapshot
// copy of every counter, and a registered read mux over live or shadow values.
module pipe_event_counter #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1,
  parameter int SEL_W    = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  input  logic               rd_shadow_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               done_o
);

  localparam int NCH = NUM_EVT + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] ALL1 = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [CNT_W-1:0] shd     [NCH];
  logic [CNT_W-1:0] shd_nxt [NCH];
  logic [NUM_EVT:0] ovf, ovf_nxt;
  logic [NCH-1:0]   inc;
  logic             counting;
  logic             arm;
  logic             stop;
  logic [CNT_W-1:0] rd_nxt;
  logic [CNT_W-1:0] rd_data_p1;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (v == ALL1) return (SATURATE != 0) ? ALL1 : '0;
    return v + ONE;
  endfunction

  assign counting = (state == S_RUN) && start_i;
  assign arm      = (state == S_IDLE) && start_i;
  // Channel 0 is the cycle counter and always advances while counting.
  assign inc      = {evt_i, 1'b1} & {NCH{counting}};

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_nxt[k] = cnt[k];
      if (clr_i || arm)  cnt_nxt[k] = '0;
      else if (inc[k])   cnt_nxt[k] = bump(cnt[k]);
      shd_nxt[k] = shd[k];
      if (clr_i)         shd_nxt[k] = '0;
      else if (snap_i)   shd_nxt[k] = cnt[k];
      ovf_nxt[k] = clr_i ? 1'b0 : (ovf[k] | (inc[k] && (cnt[k] == ALL1)));
    end
  end

  // A saturated or already-passed count never re-matches, so no late stop.
  assign stop = counting && (limit_i != '0) && (cnt_nxt[0] == limit_i) &&
                (cnt[0] != limit_i);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (clr_i) state_nxt = S_IDLE;
  end

  // Read mux looks at post-edge values so a live read includes this edge's increment.
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_nxt = rd_shadow_i ? shd_nxt[k] : cnt_nxt[k];
    end
  end

  // Register stage: FSM, counters, shadows, flags and read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      ovf        <= '0;
      rd_data_p1 <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt[k] <= '0;
        shd[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      ovf        <= ovf_nxt;
      rd_data_p1 <= rd_nxt;
      for (int k = 0; k < NCH; k++) begin
        cnt[k] <= cnt_nxt[k];
        shd[k] <= shd_nxt[k];
      end
    end
  end

  assign rd_data_o = rd_data_p1;
  assign ovf_o     = ovf;
  assign running_o = (state == S_RUN);
  assign done_o    = (state == S_DONE);

endmodule
